// File: rtl/ad9361_pkg.sv
// ---------------------------------------------------------------------------
// ad9361_pkg
// Shared definitions for the AD9361 register-initialisation sequencer.
//   - command op codes carried in op[27:26] of each table entry
//   - bit positions of the entry fields (op / addr / data / mask)
//   - sequencer FSM state encoding
//   - small field-extraction helpers and the POLL match test
// ---------------------------------------------------------------------------
package ad9361_pkg;

  localparam int ENTRY_W  = 28;
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 26;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 8;
  localparam int MASK_MSB = 7;
  localparam int MASK_LSB = 0;

  localparam int SPI_AW   = 10;
  localparam int SPI_DW   = 8;

  // Wide enough for a 16-bit WAIT count times any practical DELAY_UNIT.
  localparam int TMR_W    = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_WAIT  = 2'd1,
    OP_POLL  = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_XFER   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DELAY  = 3'd5,
    ST_FINISH = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  function automatic op_e entry_op(input logic [ENTRY_W-1:0] e);
    return op_e'(e[OP_MSB:OP_LSB]);
  endfunction

  function automatic logic [SPI_AW-1:0] entry_addr(input logic [ENTRY_W-1:0] e);
    return e[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic [SPI_DW-1:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[DATA_MSB:DATA_LSB];
  endfunction

  function automatic logic [SPI_DW-1:0] entry_mask(input logic [ENTRY_W-1:0] e);
    return e[MASK_MSB:MASK_LSB];
  endfunction

  function automatic logic poll_match(input logic [SPI_DW-1:0] rd,
                                      input logic [SPI_DW-1:0] data,
                                      input logic [SPI_DW-1:0] mask);
    return ((rd & mask) == (data & mask));
  endfunction

endpackage

// File: rtl/ad9361_seq_timer.sv
// ---------------------------------------------------------------------------
// ad9361_seq_timer
// Loadable down-counter with a zero flag, shared by WAIT delays and the gap
// between successive POLL reads.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : load load_val this cycle (takes priority over dec)
//   load_val    : value to load
//   dec         : decrement by one (saturates at zero)
//   zero        : count is zero
// ---------------------------------------------------------------------------
module ad9361_seq_timer
  import ad9361_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ad9361_init_seq.sv
// ---------------------------------------------------------------------------
// ad9361_init_seq
// Walks a command table held in an external registered ROM and issues
// single-register reads/writes through the ad9361_spi master port.
// Commands: WRITE, WAIT (delay in DELAY_UNIT cycles), POLL (read until the
// masked readback matches, with POLL_GAP cycles between reads and a timeout
// after POLL_MAX reads) and END.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : one-cycle pulse, run the table from entry 0
//   busy/done/error     : status levels; err_index = failing POLL entry
//   rom_addr / rom_data : table address out, entry in (1-cycle latency)
//   spi_*               : read/write/waitrequest port of the SPI master
// ---------------------------------------------------------------------------
module ad9361_init_seq
  import ad9361_pkg::*;
#(
  parameter int ROM_AW     = 8,
  parameter int DELAY_UNIT = 1000,
  parameter int POLL_GAP   = 256,
  parameter int POLL_MAX   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ROM_AW-1:0]   err_index,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [ENTRY_W-1:0]  rom_data,
  output logic                spi_read,
  output logic                spi_write,
  output logic [SPI_AW-1:0]   spi_address,
  output logic [SPI_DW-1:0]   spi_writedata,
  input  logic [SPI_DW-1:0]   spi_readdata,
  input  logic                spi_waitrequest
);

  localparam int ATT_W = $clog2(POLL_MAX + 1);

  state_e               state_d, state_q;
  logic [ROM_AW-1:0]    index_d, index_q;
  logic [ATT_W-1:0]     attempt_d, attempt_q;
  logic [ENTRY_W-1:0]   entry_d, entry_q;
  logic [SPI_DW-1:0]    rd_d, rd_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 error_d, error_q;
  logic [ROM_AW-1:0]    err_index_d, err_index_q;
  logic                 spi_read_d, spi_read_q;
  logic                 spi_write_d, spi_write_q;
  logic [SPI_AW-1:0]    spi_address_d, spi_address_q;
  logic [SPI_DW-1:0]    spi_writedata_d, spi_writedata_q;

  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_load_val;
  logic                 tmr_dec;
  logic                 tmr_zero;
  logic                 adv;
  logic [15:0]          wait_cnt;

  ad9361_seq_timer #(
    .W        (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d         = state_q;
    index_d         = index_q;
    attempt_d       = attempt_q;
    entry_d         = entry_q;
    rd_d            = rd_q;
    busy_d          = busy_q;
    done_d          = done_q;
    error_d         = error_q;
    err_index_d     = err_index_q;
    spi_read_d      = spi_read_q;
    spi_write_d     = spi_write_q;
    spi_address_d   = spi_address_q;
    spi_writedata_d = spi_writedata_q;
    tmr_load        = 1'b0;
    tmr_load_val    = '0;
    tmr_dec         = 1'b0;
    adv             = 1'b0;
    wait_cnt        = rom_data[DATA_MSB:MASK_LSB];

    case (state_q)
      // FINISH/FAULT last one cycle; a start there is accepted like in IDLE.
      ST_IDLE, ST_FINISH, ST_FAULT: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_FETCH;
          index_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // rom_addr (= index) is already stable; the ROM registers it this cycle.
      ST_FETCH: begin
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        entry_d = rom_data;
        case (entry_op(rom_data))
          OP_WRITE: begin
            spi_address_d   = entry_addr(rom_data);
            spi_writedata_d = entry_data(rom_data);
            spi_write_d     = 1'b1;
            state_d         = ST_XFER;
          end
          OP_POLL: begin
            spi_address_d = entry_addr(rom_data);
            spi_read_d    = 1'b1;
            attempt_d     = ATT_W'(1);
            state_d       = ST_XFER;
          end
          OP_WAIT: begin
            if (wait_cnt == '0) begin
              adv = 1'b1;
            end else begin
              // DELAY exits on the cycle the timer reads zero, so load N*U-1
              // to spend exactly N*U cycles there.
              tmr_load     = 1'b1;
              tmr_load_val = TMR_W'(wait_cnt) * TMR_W'(DELAY_UNIT) - TMR_W'(1);
              state_d      = ST_DELAY;
            end
          end
          default: begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        endcase
      end

      // Strobe and address/data are held until the master reports completion;
      // dropping the strobe on that same edge keeps the master from re-arming.
      ST_XFER: begin
        if (!spi_waitrequest) begin
          spi_read_d  = 1'b0;
          spi_write_d = 1'b0;
          rd_d        = spi_readdata;
          if (entry_op(entry_q) == OP_POLL) begin
            state_d = ST_CHECK;
          end else begin
            adv = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        if (poll_match(rd_q, entry_data(entry_q), entry_mask(entry_q))) begin
          adv = 1'b1;
        end else if (attempt_q >= ATT_W'(POLL_MAX)) begin
          state_d     = ST_FAULT;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          err_index_d = index_q;
        end else begin
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(POLL_GAP - 1);
          state_d      = ST_DELAY;
        end
      end

      // Shared by WAIT and POLL gaps; the latched op tells them apart.
      ST_DELAY: begin
        if (tmr_zero) begin
          if (entry_op(entry_q) == OP_POLL) begin
            spi_address_d = entry_addr(entry_q);
            spi_read_d    = 1'b1;
            attempt_d     = attempt_q + ATT_W'(1);
            state_d       = ST_XFER;
          end else begin
            adv = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The last table slot ends the sequence even without an END entry.
    if (adv) begin
      if (index_q == {ROM_AW{1'b1}}) begin
        state_d = ST_FINISH;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        index_d = index_q + ROM_AW'(1);
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      index_q         <= '0;
      attempt_q       <= '0;
      entry_q         <= '0;
      rd_q            <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      err_index_q     <= '0;
      spi_read_q      <= 1'b0;
      spi_write_q     <= 1'b0;
      spi_address_q   <= '0;
      spi_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      attempt_q       <= attempt_d;
      entry_q         <= entry_d;
      rd_q            <= rd_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      err_index_q     <= err_index_d;
      spi_read_q      <= spi_read_d;
      spi_write_q     <= spi_write_d;
      spi_address_q   <= spi_address_d;
      spi_writedata_q <= spi_writedata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = err_index_q;
  assign rom_addr      = index_q;
  assign spi_read      = spi_read_q;
  assign spi_write     = spi_write_q;
  assign spi_address   = spi_address_q;
  assign spi_writedata = spi_writedata_q;

endmodule

// File: tb/tb_ad9361_init_seq.sv
// ---------------------------------------------------------------------------
// tb_ad9361_init_seq
// Bench for ad9361_init_seq with a registered ROM model and a simple SPI
// master model (random completion latency, one-cycle waitrequest low).
// Expected behaviour comes from a table-level model: the list of entries,
// the POLL response list and the cycle costs of FETCH/DECODE/DELAY/CHECK.
// ---------------------------------------------------------------------------
module tb_ad9361_init_seq;

  localparam int ROM_AW     = 3;
  localparam int DEPTH      = 8;
  localparam int DELAY_UNIT = 10;
  localparam int POLL_GAP   = 8;
  localparam int POLL_MAX   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, error;
  logic [ROM_AW-1:0] err_index, rom_addr;
  logic [27:0]       rom_data = '0;
  logic              spi_read, spi_write;
  logic [9:0]        spi_address;
  logic [7:0]        spi_writedata;
  logic [7:0]        spi_readdata = '0;
  logic              spi_waitrequest = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ad9361_init_seq #(
    .ROM_AW          (ROM_AW),
    .DELAY_UNIT      (DELAY_UNIT),
    .POLL_GAP        (POLL_GAP),
    .POLL_MAX        (POLL_MAX)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .err_index       (err_index),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .spi_read        (spi_read),
    .spi_write       (spi_write),
    .spi_address     (spi_address),
    .spi_writedata   (spi_writedata),
    .spi_readdata    (spi_readdata),
    .spi_waitrequest (spi_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Registered ROM
  logic [27:0] rom [DEPTH];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SPI master model
  logic [7:0] poll_q [$];
  logic       active = 1'b0;
  int         lat = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      spi_waitrequest <= 1'b1;
      active          <= 1'b0;
      lat             <= 0;
    end else if (!spi_waitrequest) begin
      spi_waitrequest <= 1'b1;
      active          <= 1'b0;
    end else if (active) begin
      if (lat == 0) begin
        spi_waitrequest <= 1'b0;
        if (spi_read && poll_q.size() > 0) spi_readdata <= poll_q.pop_front();
        else                               spi_readdata <= 8'h00;
      end else begin
        lat <= lat - 1;
      end
    end else if (spi_read || spi_write) begin
      active <= 1'b1;
      lat    <= $urandom_range(3, 0);
    end
  end

  // Monitor: transaction log, rom_addr changes, strobe rises, protocol rules
  typedef struct packed {
    logic       rd;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         cyc;
  } txn_t;

  txn_t              txq [$];
  int                ra_cyc [$];
  logic [ROM_AW-1:0] ra_val [$];
  int                rd_rise [$];
  int                any_rise [$];
  int                proto_viol = 0;
  logic [ROM_AW-1:0] prev_addr = '0;
  logic              prev_strobe = 1'b0, prev_wr_low = 1'b0, prev_rst_n = 1'b0;
  logic [9:0]        prev_a = '0;
  logic [7:0]        prev_d = '0;

  always @(negedge clk) begin
    logic strobe;
    strobe = spi_read | spi_write;
    if (rst_n && !spi_waitrequest)
      txq.push_back('{rd: spi_read, addr: spi_address, wdata: spi_writedata,
                      rdata: spi_readdata, cyc: cyc});
    if (rom_addr != prev_addr) begin
      ra_cyc.push_back(cyc);
      ra_val.push_back(rom_addr);
    end
    if (strobe && !prev_strobe) begin
      any_rise.push_back(cyc);
      if (spi_read) rd_rise.push_back(cyc);
    end
    if (spi_read && spi_write) proto_viol++;
    if (rst_n && prev_rst_n) begin
      if (prev_wr_low && strobe) proto_viol++;
      if (prev_strobe && !prev_wr_low &&
          (!strobe || spi_address != prev_a || spi_writedata != prev_d)) proto_viol++;
    end
    prev_addr   = rom_addr;
    prev_strobe = strobe;
    prev_wr_low = !spi_waitrequest;
    prev_rst_n  = rst_n;
    prev_a      = spi_address;
    prev_d      = spi_writedata;
  end

  // Table entry builders
  function automatic logic [27:0] e_write(input logic [9:0] a, input logic [7:0] d);
    return {2'd0, a, d, 8'h00};
  endfunction
  function automatic logic [27:0] e_wait(input logic [15:0] n);
    return {2'd1, 10'd0, n};
  endfunction
  function automatic logic [27:0] e_poll(input logic [9:0] a, input logic [7:0] d,
                                         input logic [7:0] m);
    return {2'd2, a, d, m};
  endfunction
  function automatic logic [27:0] e_end();
    return {2'd3, 26'd0};
  endfunction

  function automatic int cyc_of_addr(input logic [ROM_AW-1:0] v);
    foreach (ra_val[i]) if (ra_val[i] == v) return ra_cyc[i];
    return -100000;
  endfunction

  function automatic int count_reads();
    int n = 0;
    foreach (txq[i]) if (txq[i].rd) n++;
    return n;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < DEPTH; i++) rom[i] = e_end();
    txq.delete(); ra_cyc.delete(); ra_val.delete();
    rd_rise.delete(); any_rise.delete(); poll_q.delete();
  endtask

  // Pulse start, check the accepted-start state, wait for busy to fall.
  task automatic run_seq(input int budget);
    int n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({busy, done, error, rom_addr} !== {1'b1, 1'b0, 1'b0, {ROM_AW{1'b0}}}) begin
      errors++;
      $display("FAIL start_accept: busy=%0b done=%0b error=%0b rom_addr=%0d, required 1 0 0 0",
               busy, done, error, rom_addr);
    end
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL run_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, err_index, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_status: busy=%0b done=%0b error=%0b err_index=%0d rom_addr=%0d, required all 0",
               busy, done, error, err_index, rom_addr);
    end
    checks++;
    if ({spi_read, spi_write, spi_address, spi_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_spi: read=%0b write=%0b addr=%h wdata=%h, required all 0",
               spi_read, spi_write, spi_address, spi_writedata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_seq();
    logic [23:0] exp_cmd [2];
    clear_all();
    rom[0] = e_write(10'h3DF, 8'h01);
    rom[1] = e_write(10'h2A6, 8'h0E);
    exp_cmd[0] = 24'h83DF01;
    exp_cmd[1] = 24'h82A60E;
    run_seq(500);
    checks++;
    if (txq.size() != 2) begin
      errors++;
      $display("FAIL write_count: got %0d transfers, required 2", txq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [23:0] cmd;
        cmd = {~txq[i].rd, 5'b0, txq[i].addr, txq[i].wdata};
        checks++;
        if (cmd !== exp_cmd[i]) begin
          errors++;
          $display("FAIL write_cmd%0d: got %h, required %h", i, cmd, exp_cmd[i]);
        end
      end
      // completion sampled next edge, then FETCH and DECODE before the next strobe
      checks++;
      if (any_rise.size() != 2 || any_rise[1] - txq[0].cyc != 3) begin
        errors++;
        $display("FAIL write_overhead: rises=%0d gap=%0d, required 2 rises gap 3",
                 any_rise.size(), (any_rise.size() > 1) ? any_rise[1] - txq[0].cyc : -1);
      end
    end
    checks++;
    if ({done, busy, error} !== 3'b100) begin
      errors++;
      $display("FAIL write_status: done=%0b busy=%0b error=%0b, required 1 0 0", done, busy, error);
    end
  endtask

  task automatic test_wait();
    int c1, c2, c3, c4;
    clear_all();
    rom[0] = e_write(10'($urandom), 8'($urandom));
    rom[1] = e_wait(16'd3);
    rom[2] = e_write(10'($urandom), 8'($urandom));
    rom[3] = e_wait(16'd0);
    rom[4] = e_write(10'($urandom), 8'($urandom));
    run_seq(1000);
    checks++;
    if (txq.size() != 3 || txq[0].wdata !== rom[0][15:8] || txq[1].addr !== rom[2][25:16] ||
        txq[2].wdata !== rom[4][15:8]) begin
      errors++;
      $display("FAIL wait_txns: count=%0d, required 3 writes matching entries 0,2,4", txq.size());
    end
    c1 = cyc_of_addr(3'd1);
    c2 = cyc_of_addr(3'd2);
    c3 = cyc_of_addr(3'd3);
    c4 = cyc_of_addr(3'd4);
    checks++;
    if (txq.size() < 1 || c1 - txq[0].cyc != 1) begin
      errors++;
      $display("FAIL wait_advance: rom_addr->1 at %0d, required one cycle after completion", c1);
    end
    // FETCH + DECODE of the WAIT entry, then 3*DELAY_UNIT cycles in DELAY
    checks++;
    if (c2 - c1 != 2 + 3 * DELAY_UNIT) begin
      errors++;
      $display("FAIL wait_delay: got %0d cycles, required %0d", c2 - c1, 2 + 3 * DELAY_UNIT);
    end
    checks++;
    if (c4 - c3 != 2) begin
      errors++;
      $display("FAIL wait_zero: got %0d cycles, required 2", c4 - c3);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%0b, required 1", done);
    end
  endtask

  task automatic test_poll_plan();
    clear_all();
    rom[0] = e_poll(10'h247, 8'h02, 8'h02);
    rom[1] = e_write(10'($urandom), 8'($urandom));
    poll_q.push_back(8'h00);
    poll_q.push_back(8'h00);
    poll_q.push_back(8'h02);
    run_seq(1000);
    checks++;
    if (txq.size() != 4 || count_reads() != 3 || txq[3].rd !== 1'b0) begin
      errors++;
      $display("FAIL poll_txns: total=%0d reads=%0d, required 4 and 3", txq.size(), count_reads());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (txq[k].addr !== 10'h247) begin
          errors++;
          $display("FAIL poll_addr%0d: got %h, required 247", k, txq[k].addr);
        end
      end
      // CHECK cycle + POLL_GAP DELAY cycles after the completion sample edge
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (rd_rise.size() != 3 || rd_rise[k] - txq[k-1].cyc != POLL_GAP + 2) begin
          errors++;
          $display("FAIL poll_gap%0d: got %0d, required %0d", k,
                   (rd_rise.size() == 3) ? rd_rise[k] - txq[k-1].cyc : -1, POLL_GAP + 2);
        end
      end
    end
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("FAIL poll_status: done=%0b error=%0b, required 1 0", done, error);
    end
  endtask

  task automatic test_poll_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] m, d, r;
      int hit, exp_reads, exp_total;
      clear_all();
      m = 8'($urandom_range(255, 1));
      d = 8'($urandom);
      rom[0] = e_write(10'($urandom), 8'($urandom));
      rom[1] = e_poll(10'($urandom), d, m);
      rom[2] = e_write(10'($urandom), 8'($urandom));
      hit = -1;
      for (int i = 0; i < POLL_MAX; i++) begin
        r = 8'($urandom);
        if ($urandom_range(2, 0) == 0) r = (r & ~m) | (d & m);
        poll_q.push_back(r);
        if (hit < 0 && ((r & m) == (d & m))) hit = i;
      end
      exp_reads = (hit >= 0) ? hit + 1 : POLL_MAX;
      exp_total = 1 + exp_reads + ((hit >= 0) ? 1 : 0);
      run_seq(2000);
      checks++;
      if (count_reads() != exp_reads || txq.size() != exp_total) begin
        errors++;
        $display("FAIL poll_rand%0d_count: reads=%0d total=%0d, required %0d and %0d",
                 it, count_reads(), txq.size(), exp_reads, exp_total);
      end
      checks++;
      if (hit >= 0 ? ({done, error} !== 2'b10)
                   : ({done, error, err_index} !== {2'b01, 3'd1})) begin
        errors++;
        $display("FAIL poll_rand%0d_status: done=%0b error=%0b err_index=%0d, required match=%0b",
                 it, done, error, err_index, hit >= 0);
      end
    end
  endtask

  task automatic test_timeout();
    clear_all();
    rom[0] = e_write(10'($urandom), 8'($urandom));
    rom[1] = e_write(10'($urandom), 8'($urandom));
    rom[2] = e_poll(10'h010, 8'h02, 8'h02);
    rom[3] = e_write(10'($urandom), 8'($urandom));
    run_seq(2000);
    checks++;
    if (count_reads() != POLL_MAX || txq.size() != 2 + POLL_MAX) begin
      errors++;
      $display("FAIL timeout_count: reads=%0d total=%0d, required %0d and %0d",
               count_reads(), txq.size(), POLL_MAX, 2 + POLL_MAX);
    end
    checks++;
    if ({error, done, busy, err_index} !== {3'b100, 3'd2}) begin
      errors++;
      $display("FAIL timeout_status: error=%0b done=%0b busy=%0b err_index=%0d, required 1 0 0 2",
               error, done, busy, err_index);
    end
  endtask

  task automatic test_no_end();
    clear_all();
    for (int i = 0; i < DEPTH; i++) rom[i] = e_write(10'($urandom), 8'($urandom));
    run_seq(1000);
    repeat (20) @(negedge clk);
    checks++;
    if (txq.size() != DEPTH) begin
      errors++;
      $display("FAIL noend_count: got %0d transfers, required %0d", txq.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if ({txq[i].addr, txq[i].wdata} !== rom[i][25:8]) begin
          errors++;
          $display("FAIL noend_entry%0d: got %h/%h, required %h/%h", i,
                   txq[i].addr, txq[i].wdata, rom[i][25:16], rom[i][15:8]);
        end
      end
    end
    checks++;
    if ({done, busy, rom_addr} !== {2'b10, 3'd7}) begin
      errors++;
      $display("FAIL noend_final: done=%0b busy=%0b rom_addr=%0d, required 1 0 7", done, busy, rom_addr);
    end
  endtask

  task automatic test_reset_midxfer();
    int n = 0;
    int ntx, nrise;
    clear_all();
    for (int i = 0; i < 4; i++) rom[i] = e_write(10'($urandom), 8'($urandom));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!(spi_write && rom_addr == 3'd2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(spi_write && rom_addr == 3'd2)) begin
      errors++;
      $display("FAIL midxfer_reach: write=%0b rom_addr=%0d, required 1 2", spi_write, rom_addr);
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({spi_write, busy, rom_addr} !== {2'b11, 3'd2}) begin
      errors++;
      $display("FAIL ignored_start: write=%0b busy=%0b rom_addr=%0d, required 1 1 2",
               spi_write, busy, rom_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, error, err_index, rom_addr, spi_read, spi_write, spi_address, spi_writedata} !== '0) begin
      errors++;
      $display("FAIL midxfer_reset: busy=%0b write=%0b addr=%h rom_addr=%0d, required all 0",
               busy, spi_write, spi_address, rom_addr);
    end
    rst_n = 1'b1;
    ntx = txq.size();
    nrise = any_rise.size();
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || txq.size() != ntx || any_rise.size() != nrise || rom_addr !== 3'd0) begin
      errors++;
      $display("FAIL no_restart: busy=%0b new_txns=%0d new_strobes=%0d rom_addr=%0d, required 0 0 0 0",
               busy, txq.size() - ntx, any_rise.size() - nrise, rom_addr);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_viol != 0) begin
      errors++;
      $display("FAIL spi_protocol: %0d violations, required 0", proto_viol);
    end
  endtask

  initial begin
    clear_all();
    test_reset();
    test_write_seq();
    test_wait();
    test_poll_plan();
    test_poll_random();
    test_timeout();
    test_no_end();
    test_reset_midxfer();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
